// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter constants, FSM encoding and one-hot index helper
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int REQ_IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  function automatic int onehot_lowest_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/grant_decode.sv
// grant_decode: maps a grant vector to owner index, valid and multi-hot flag
//   i_gnt: grant vector; o_idx: lowest set index; o_vld: any bit set; o_multi: more than one bit set
module grant_decode
  import arb_pkg::*;
#(
  parameter int NUM  = NUM_REQ,
  parameter int IDXW = REQ_IDXW
) (
  input  logic [NUM-1:0]  i_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_vld,
  output logic            o_multi
);
  always_comb begin
    o_idx = IDXW'(onehot_lowest_idx(32'(i_gnt)));
    o_vld = |i_gnt;
    o_multi = |(i_gnt & (i_gnt - 1'b1));
  end
endmodule

// File: rtl/grant_burst_mux.sv
// grant_burst_mux: latches the granted requester and forwards its burst to one registered output
//   gnt/hold: arbiter handshake; in_*: per-requester beats; out_*: registered output beat;
//   err_multi_gnt: sticky flag for a multi-hot grant taken in IDLE
module grant_burst_mux
  import arb_pkg::*;
#(
  parameter int NUM       = NUM_REQ,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16,
  parameter int IDXW      = REQ_IDXW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM-1:0]    gnt,
  input  logic [NUM*DW-1:0] in_data,
  input  logic [NUM-1:0]    in_valid,
  input  logic [NUM-1:0]    in_last,
  output logic [NUM-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [IDXW-1:0]   out_src,
  input  logic              out_ready,
  output logic              hold,
  output logic              err_multi_gnt
);
  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  state_t r_state;
  logic [IDXW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic [IDXW-1:0] w_idx;
  logic w_gvld, w_multi, w_free, w_accept, w_last;
  logic [DW-1:0] w_data;
  grant_decode #(.NUM(NUM), .IDXW(IDXW)) u_dec (
    .i_gnt(gnt),
    .o_idx(w_idx),
    .o_vld(w_gvld),
    .o_multi(w_multi)
  );
  always_comb begin
    w_free = ~out_valid | out_ready;
    w_data = in_data[r_owner*DW +: DW];
    w_accept = (r_state == XFER) & in_valid[r_owner] & w_free;
    // forced last on the MAX_BEATS-th beat so a runaway requester cannot hog the bus
    w_last = in_last[r_owner] | (r_cnt == CW'(MAX_BEATS - 1));
    in_ready = (r_state == XFER && w_free) ? NUM'(1) << r_owner : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt <= '0;
      hold <= 1'b0;
      err_multi_gnt <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_src <= '0;
    end else begin
      if (r_state == IDLE && w_gvld) begin
        r_state <= XFER;
        hold <= 1'b1;
        r_owner <= w_idx;
        r_cnt <= '0;
        err_multi_gnt <= err_multi_gnt | w_multi;
      end
      if (w_accept) begin
        out_data <= w_data;
        out_src <= r_owner;
        out_valid <= 1'b1;
        out_last <= w_last;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_state <= IDLE;
          hold <= 1'b0;
        end
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_grant_burst_mux.sv
// tb_grant_burst_mux: scoreboard bench for grant_burst_mux with directed bursts
module tb_grant_burst_mux;
  localparam int NUM = 4, DW = 8, MAXB = 4;
  logic clk = 0, reset = 0, out_ready = 1;
  logic [NUM-1:0] gnt = 0, in_valid = 0, in_last = 0, in_ready;
  logic [NUM*DW-1:0] in_data = 0;
  logic [DW-1:0] out_data;
  logic out_valid, out_last, hold, err_multi_gnt;
  logic [1:0] out_src;
  typedef struct packed {logic [7:0] d; logic l; logic [1:0] s;} beat_t;
  beat_t exp_q[$];
  int checks = 0, errors = 0;

  grant_burst_mux #(.NUM(NUM), .DW(DW), .MAX_BEATS(MAXB), .IDXW(2)) dut (
    .clk(clk), .reset(reset), .gnt(gnt), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_src(out_src), .out_ready(out_ready), .hold(hold),
    .err_multi_gnt(err_multi_gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", {out_data, out_last, out_src});
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat{data,last,src}", {out_data, out_last, out_src}, e);
      end
    end
  end

  task automatic grant(input logic [3:0] g);
    @(posedge clk); #1;
    gnt = g;
    @(posedge clk); #1;
    gnt = 0;
  endtask

  task automatic send(input int r, input logic [7:0] d[6], input int n, input bit lst);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      in_valid[r] = 1'b1;
      in_data[r*8 +: 8] = d[k];
      in_last[r] = lst && (k == n - 1);
      @(negedge clk);
      while (!in_ready[r] && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t == 50) check("in_ready_timeout", 0, 1);
      exp_q.push_back('{d[k], (lst && k == n - 1) || k == MAXB - 1, 2'(r)});
      @(posedge clk); #1;
    end
    in_valid[r] = 1'b0;
    in_last[r] = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset = 1;
    gnt = 4'($urandom);
    in_valid = 4'($urandom);
    in_last = 4'($urandom);
    in_data = $urandom;
    out_ready = 1'($urandom);
    #1;
    check("rst_async_outputs", {in_ready, out_data, out_valid, out_last, out_src, hold, err_multi_gnt}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_outputs", {in_ready, out_data, out_valid, out_last, out_src, hold, err_multi_gnt}, 0);
    @(negedge clk);
    gnt = 0; in_valid = 0; in_last = 0; in_data = 0; out_ready = 1;
    reset = 0;
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_hold_ready", {hold, in_ready}, 0);
    end

    grant(4'b0100);
    check("t2_hold_rise", hold, 1);
    check("t2_no_err", err_multi_gnt, 0);
    fork
      send(2, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, 3, 1);
      begin
        @(posedge clk); #1;
        check("t2_first_beat_latency", {out_valid, out_data, out_src}, {1'b1, 8'h11, 2'd2});
      end
    join
    check("t2_hold_drop", hold, 0);
    drain("t2_drain");

    grant(4'b0100);
    fork
      send(2, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, 3, 1);
      begin
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
          @(posedge clk); #1;
          t++;
        end
        out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          check("t3_stall_data", out_data, 8'h11);
          check("t3_stall_in_ready", in_ready[2], 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain("t3_drain");

    grant(4'b0001);
    send(0, '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6}, 4, 0);
    in_valid[0] = 1'b1;
    in_data[7:0] = 8'hA5;
    check("t4_hold_after_force", hold, 0);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_ready_after_force", in_ready[0], 0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    drain("t4_drain");
    repeat (2) @(negedge clk);
    check("t4_no_extra_beats", out_valid, 0);

    grant(4'b1010);
    check("t5_err_set", err_multi_gnt, 1);
    check("t5_hold", hold, 1);
    fork
      send(1, '{8'h51, 8'h52, 8'h53, 8'h00, 8'h00, 8'h00}, 3, 1);
      begin
        @(posedge clk); #1;
        gnt = 4'b1000;
        @(posedge clk); #1;
        gnt = 0;
      end
    join
    drain("t5_drain");
    repeat (2) begin
      @(posedge clk); #1;
      check("t5_idle_after_ignored_gnt", hold, 0);
    end
    check("t5_err_sticky", err_multi_gnt, 1);

    grant(4'b1000);
    send(3, '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h00}, 2, 0);
    reset = 1;
    #1;
    check("t6_reset_mid_burst", {out_valid, hold, in_ready}, 0);
    check("t6_err_cleared", err_multi_gnt, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    grant(4'b0001);
    check("t6_hold_after_regrant", hold, 1);
    send(0, '{8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1);
    drain("t6_drain");
    check("t6_hold_end", hold, 0);
    check("t6_err_stays_clear", err_multi_gnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grant_burst_mux.md
Name: grant_burst_mux

Overview:
- Sits directly downstream of the NUM-way arbiter and consumes its one-hot gnt vector.
- Latches the granted requester as the bus owner and forwards that requester's multi-beat burst onto one shared valid/ready output. The output is registered.
- Releases ownership after the burst's last beat, or forcibly at MAX_BEATS.
- While busy, drives hold to the arbiter so no new grant is issued mid-burst.

Parameters:
NUM, 4, number of requesters (must match the arbiter's width)
DW, 8, data width per requester
MAX_BEATS, 16, maximum beats per burst before forced termination (at least 1)
IDXW, 2, width of the owner index, equal to clog2(NUM)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
gnt  input  NUM  one-hot grant from the arbiter
in_data  input  NUM*DW  per-requester data, flattened; requester i occupies bits [i*DW +: DW]
in_valid  input  NUM  per-requester beat valid
in_last  input  NUM  per-requester last-beat flag
in_ready  output  NUM  per-requester ready; only the owner's bit can be 1
out_data  output  DW  registered output data
out_valid  output  1  output beat valid
out_last  output  1  output last flag (set on a real or forced last beat)
out_src  output  IDXW  owner index of the current output beat
out_ready  input  1  downstream ready
hold  output  1  high while a burst is owned; arbiter must not grant
err_multi_gnt  output  1  sticky flag; set when gnt has more than one bit high

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, out_src=0, hold=0, err_multi_gnt=0, beat counter=0.
- States: IDLE and XFER.
- IDLE, gnt==0: stay in IDLE.
- IDLE, gnt!=0: latch owner = index of the lowest set bit, clear the beat counter, go to XFER on the next edge.
- gnt with more than one bit high: owner = lowest index; set err_multi_gnt, which stays set until reset.
- gnt is ignored in XFER: no ownership change, no error.
- hold = (state==XFER), registered. It rises the cycle after the accepted gnt.
- Output stage: out_slot_free = ~out_valid | out_ready.
- In XFER: in_ready[owner] = out_slot_free (combinational); all other in_ready bits = 0. In IDLE all in_ready bits = 0.
- Beat accept: in_valid[owner] & in_ready[owner]. On accept, the next edge loads out_data, out_src=owner, out_valid=1, out_last = in_last[owner] | (count==MAX_BEATS-1). The counter increments.
- If out_ready is high and no new beat is accepted, out_valid clears. Without out_ready, out_* hold stable (no change while out_valid & ~out_ready).
- Termination: an accepted beat with out_last=1 sends the FSM to IDLE on the same edge.
  - A gnt can be taken the following cycle (IDLE evaluation), so back-to-back bursts have a one-cycle gap on in_ready.
  - A requester still sending after a forced termination must re-request; the extra beats are not consumed.
- Latency: gnt at edge T gives in_ready at T+1; a beat presented at T+1 appears on out_* at T+2.
- Simultaneous events:
  - Last-beat accept and a gnt in the same cycle: the gnt is ignored (state was XFER).
  - out_ready pop and a new accept in the same cycle: the output is replaced, with no bubble.
- Owner in_valid low: no accept, the counter does not advance, no timeout on idle cycles.
- Reset mid-burst: all state clears immediately, including out_valid; any partial burst is discarded.

Decomposition:
- Shared package arb_pkg:
  - constants NUM_REQ=4 and the IDXW derivation;
  - an FSM state encoding (IDLE=0, XFER=1);
  - a function onehot_lowest_idx(vector) returning the index.
- The arbiter uses the same NUM_REQ.
- One natural sub-module: grant_decode, which maps gnt to an owner index, a valid bit and a multi-hot flag. It is purely combinational and reusable by other gnt consumers.
- The remainder (FSM, counter, output register) stays in the top.

Test Plan:
1. Reset: assert reset with all inputs random -> all outputs 0. Release with gnt=0 -> stays IDLE and hold=0 for 5 cycles.
2. Single burst: gnt=4'b0100 for one cycle; requester 2 sends data 0x11, 0x22, 0x33 (last on 0x33); out_ready=1 -> out beats 0x11, 0x22, 0x33 with out_src=2, starting 2 cycles after gnt. out_last is high only on 0x33; hold drops the cycle after the last accept.
3. Backpressure: repeat scenario 2 with out_ready low for 3 cycles after the first beat -> out_data holds 0x11 and in_ready[2]=0 throughout the stall. There is no loss or duplication; order is preserved.
4. Forced termination: MAX_BEATS=4; requester 0 streams 6 beats with no last -> exactly 4 beats are forwarded, the 4th with out_last=1, then IDLE. in_ready[0]=0 after that.
5. Multi-hot and mid-burst gnt: gnt=4'b1010 -> owner=1 and err_multi_gnt=1 (sticky). gnt=4'b1000 during that burst -> ignored, out_src remains 1.
6. Reset mid-burst: assert reset after 2 beats of a 5-beat burst -> out_valid, hold and in_ready are 0 immediately. After release, a new gnt=4'b0001 burst completes normally.
